// File: rtl/booth_seq_mult.sv
// Sequential signed Booth multiplier: one recoded digit per clock, start/done handshake.
// Define BOOTH_SEQ_RADIX8_EN for radix-8 recoding with a one-cycle 3a precompute state.
module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
`ifdef BOOTH_SEQ_RADIX8_EN
    localparam int SH     = 3;
    localparam int NSTEPS = (WIDTH + 2) / 3;
    localparam int GW     = 4;
    typedef enum logic [1:0] {IDLE, PRECOMP, RUN, DONE} state_t;
`else
    localparam int SH     = 2;
    localparam int NSTEPS = WIDTH / 2;
    localparam int GW     = 3;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
    localparam int PP_W  = WIDTH + SH;
    localparam int POS   = SH * NSTEPS;
    localparam int ACC_W = POS + PP_W;
    localparam int GR_W  = SH * NSTEPS + 1;
    localparam int CW    = $clog2(NSTEPS + 1);

    state_t                   state;
    logic signed [WIDTH-1:0]  a_q;
    logic signed [GR_W-1:0]   grp;
    logic signed [ACC_W-1:0]  acc;
    logic [CW-1:0]            cnt;
    logic signed [GR_W-2:0]   b_ext;
    logic signed [PP_W-1:0]   a1, a2, pp;
    logic signed [ACC_W-1:0]  acc_sum, acc_nxt;

    assign b_ext = (GR_W-1)'($signed(b));
    assign a1    = PP_W'(a_q);
    assign a2    = a1 <<< 1;

`ifdef BOOTH_SEQ_RADIX8_EN
    logic signed [PP_W-1:0] a3, a4;
    assign a4 = a1 <<< 2;

    always_comb begin
        pp = '0;
        case (grp[GW-1:0])
            4'b0001, 4'b0010: pp = a1;
            4'b0011, 4'b0100: pp = a2;
            4'b0101, 4'b0110: pp = a3;
            4'b0111:          pp = a4;
            4'b1000:          pp = -a4;
            4'b1001, 4'b1010: pp = -a3;
            4'b1011, 4'b1100: pp = -a2;
            4'b1101, 4'b1110: pp = -a1;
            default:          pp = '0;
        endcase
    end
`else
    always_comb begin
        pp = '0;
        case (grp[GW-1:0])
            3'b001, 3'b010: pp = a1;
            3'b011:         pp = a2;
            3'b100:         pp = -a2;
            3'b101, 3'b110: pp = -a1;
            default:        pp = '0;
        endcase
    end
`endif

    // PP lands at bit POS so that after NSTEPS shifts of SH the result sits at bit 0.
    assign acc_sum = acc + (ACC_W'(pp) <<< POS);
    assign acc_nxt = acc_sum >>> SH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            grp     <= '0;
            acc     <= '0;
            cnt     <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
`ifdef BOOTH_SEQ_RADIX8_EN
            a3      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= a;
                        grp   <= {b_ext, 1'b0};
                        cnt   <= '0;
                        acc   <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
`ifdef BOOTH_SEQ_RADIX8_EN
                        state <= PRECOMP;
`else
                        state <= RUN;
`endif
                    end else begin
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`ifdef BOOTH_SEQ_RADIX8_EN
                PRECOMP: begin
                    a3    <= a1 + a2;
                    state <= RUN;
                end
`endif
                RUN: begin
                    acc <= acc_nxt;
                    grp <= grp >>> SH;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NSTEPS - 1)) begin
                        product <= acc_nxt[2*WIDTH-1:0];
                        done    <= 1'b1;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult: WIDTH=8 handshake/corner cases and WIDTH=16 products.
module tb_booth_seq_mult;
`ifdef BOOTH_SEQ_RADIX8_EN
    localparam int LAT16 = 8;
`else
    localparam int LAT16 = 9;
`endif
    // WIDTH=8 lands on 5 cycles for both radix-4 (4 steps) and radix-8 (precompute + 3 steps).
    localparam int LAT8 = 5;

    logic clk = 1'b0;
    logic rst;
    logic s8, rdy8, bsy8, dn8;
    logic [7:0] a8, b8;
    logic [15:0] p8;
    logic s16, rdy16, bsy16, dn16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
        .ready(rdy8), .busy(bsy8), .done(dn8), .product(p8)
    );

    booth_seq_mult #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16),
        .ready(rdy16), .busy(bsy16), .done(dn16), .product(p16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the 8-bit unit able to accept.
    task automatic mul8(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp);
        int n;
        s8 = 1'b1; a8 = x; b8 = y;
        @(negedge clk);
        s8 = 1'b0;
        n = 1;
        while (!dn8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " lat"}, 64'(n), 64'(LAT8));
        chk({tag, " prod"}, 64'(p8), 64'(exp));
        chk({tag, " rdy"}, 64'(rdy8), 64'd1);
    endtask

    task automatic mul16(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] exp);
        int n;
        s16 = 1'b1; a16 = x; b16 = y;
        @(negedge clk);
        s16 = 1'b0;
        n = 1;
        while (!dn16 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " lat"}, 64'(n), 64'(LAT16));
        chk({tag, " prod"}, 64'(p16), 64'(exp));
    endtask

    initial begin
        int n, nb, pulses;
        logic [15:0] x, y;
        logic signed [31:0] e;
        rst = 1'b1; s8 = 1'b0; a8 = '0; b8 = '0; s16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        chk("rst rdy8", 64'(rdy8), 64'd1);
        chk("rst bsy8", 64'(bsy8), 64'd0);
        chk("rst dn8", 64'(dn8), 64'd0);
        chk("rst p8", 64'(p8), 64'd0);
        chk("rst rdy16", 64'(rdy16), 64'd1);
        chk("rst p16", 64'(p16), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        mul8("7x-3", 8'd7, 8'hFD, 16'hFFEB);
        mul8("-128x-128", 8'h80, 8'h80, 16'h4000);
        mul8("-128x127", 8'h80, 8'h7F, 16'hC080);
        mul8("0x-1", 8'h00, 8'hFF, 16'h0000);
        @(negedge clk);

        // start repeated the cycle after accept must be ignored
        s8 = 1'b1; a8 = 8'd5; b8 = 8'd6;
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd9;
        nb = 0;
        while (bsy8 && nb < 20) begin
            nb++;
            @(negedge clk);
            s8 = 1'b0;
        end
        chk("ign busy cycles", 64'(nb), 64'd4);
        chk("ign done", 64'(dn8), 64'd1);
        chk("ign prod", 64'(p8), 64'h001E);
        @(negedge clk);

        // back-to-back with start held high
        s8 = 1'b1; a8 = 8'd3; b8 = 8'd4;
        @(negedge clk);
        a8 = 8'hFE; b8 = 8'd7;
        n = 1;
        while (!dn8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b lat1", 64'(n), 64'(LAT8));
        chk("b2b prod1", 64'(p8), 64'h000C);
        @(negedge clk);
        s8 = 1'b0;
        n = 1;
        while (!dn8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b gap", 64'(n), 64'd5);
        chk("b2b prod2", 64'(p8), 64'hFFF2);
        @(negedge clk);

        // reset in the second busy cycle abandons the operation
        s8 = 1'b1; a8 = 8'd100; b8 = 8'd100;
        @(negedge clk);
        s8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort rdy", 64'(rdy8), 64'd1);
        chk("abort bsy", 64'(bsy8), 64'd0);
        chk("abort dn", 64'(dn8), 64'd0);
        chk("abort prod", 64'(p8), 64'd0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (dn8) pulses++;
        end
        chk("abort no done", 64'(pulses), 64'd0);

        mul16("-1234x567", 16'hFB2E, 16'd567, 32'hFFF552E2);
        mul16("min x min", 16'h8000, 16'h8000, 32'h40000000);
        mul16("min x max", 16'h8000, 16'h7FFF, 32'hC0008000);
        for (int i = 0; i < 6; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            e = 32'($signed(x)) * 32'($signed(y));
            mul16("rand", x, y, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
